// File: rtl/frogger_pkg.sv
// frogger_pkg: shared types and constants for the frogger game-logic slice.
// Holds the collision monitor state encoding and playfield geometry.
package frogger_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        HOLD      = 2'd1,
        LEVEL     = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam int         LANE_W      = 16;
    localparam int         NUM_ROWS    = 16;
    localparam logic [3:0] GOAL_ROW    = 4'd15;
    localparam logic [3:0] SAFE_ROW    = 4'd8;
    localparam logic [2:0] MAX_SPEED_C = 3'd6;

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that stops at zero.
// load has priority over counting; zero flags a count of 0.
module hold_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/collision_monitor.sv
// collision_monitor: frog/car collision and goal detection, lives, score
// and level speed for the frogger game.
// Optional macro COLLISION_GRACE_EN adds a post-respawn immunity window
// (GRACE_CYCLES long) and the grace_active output.
module collision_monitor
    import frogger_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int HOLD_CYCLES = 25000,
    parameter int MAX_SPEED   = int'(MAX_SPEED_C)
`ifdef COLLISION_GRACE_EN
    ,
    parameter int GRACE_CYCLES = 10000
`endif
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [LANE_W*NUM_ROWS-1:0] lanes,
    input  logic [3:0]                 frog_row,
    input  logic [3:0]                 frog_col,
    input  logic                       start,
    output logic [2:0]                 speed,
    output logic [1:0]                 lives,
    output logic [7:0]                 score,
    output logic                       hit_pulse,
    output logic                       goal_pulse,
    output logic                       frog_home,
    output logic                       frozen,
    output logic                       game_over
`ifdef COLLISION_GRACE_EN
    ,
    output logic                       grace_active
`endif
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t     state_q, state_d;
    logic       occ, occ_q, occ_eff;
    logic [3:0] row_q;
    logic [7:0] cell_idx;
    logic [2:0] speed_d;
    logic [1:0] lives_d;
    logic [7:0] score_d;
    logic       hit_d, goal_d, home_d;
    logic       hold_load, hold_zero;

    function automatic logic [2:0] sat_speed(input logic [2:0] s);
        if (s >= 3'(MAX_SPEED)) begin
            return 3'(MAX_SPEED);
        end
        return s + 3'd1;
    endfunction

    // The start row and the median are never occupied, even if the lane
    // generator were to glitch a bit there.
    assign cell_idx = {frog_row, frog_col};
    assign occ      = lanes[cell_idx] & (frog_row != 4'd0) & (frog_row != SAFE_ROW);

    hold_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load),
        .load_val (HOLD_W'(HOLD_CYCLES - 1)),
        .zero     (hold_zero)
    );

`ifdef COLLISION_GRACE_EN
    localparam int GRACE_W = $clog2(GRACE_CYCLES + 1);

    logic grace_zero;

    // Every respawn restarts the immunity window.
    hold_timer #(.W(GRACE_W)) u_grace_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (home_d),
        .load_val (GRACE_W'(GRACE_CYCLES - 1)),
        .zero     (grace_zero)
    );

    assign occ_eff      = occ_q & grace_zero;
    assign grace_active = ~grace_zero;
`else
    assign occ_eff = occ_q;
`endif

    // Game rules: next state, counters and pulse requests from the sampled cell.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives;
        score_d   = score;
        speed_d   = speed;
        hit_d     = 1'b0;
        goal_d    = 1'b0;
        home_d    = 1'b0;
        hold_load = 1'b0;
        case (state_q)
            PLAY: begin
                // A collision outranks a goal reached in the same cycle.
                if (occ_eff) begin
                    hit_d   = 1'b1;
                    lives_d = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d   = HOLD;
                        hold_load = 1'b1;
                    end
                end else if (row_q == GOAL_ROW) begin
                    goal_d  = 1'b1;
                    home_d  = 1'b1;
                    score_d = score + 8'd1;
                    speed_d = sat_speed(speed);
                    state_d = LEVEL;
                end
            end
            HOLD: begin
                if (hold_zero) begin
                    home_d  = 1'b1;
                    state_d = PLAY;
                end
            end
            LEVEL: begin
                state_d = PLAY;
            end
            GAME_OVER: begin
                if (start) begin
                    lives_d = 2'(START_LIVES);
                    speed_d = 3'd0;
                    score_d = 8'd0;
                    home_d  = 1'b1;
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // Sample the frog cell and register state, counters and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PLAY;
            occ_q      <= 1'b0;
            row_q      <= 4'd0;
            speed      <= 3'd0;
            lives      <= 2'(START_LIVES);
            score      <= 8'd0;
            hit_pulse  <= 1'b0;
            goal_pulse <= 1'b0;
            frog_home  <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ;
            row_q      <= frog_row;
            speed      <= speed_d;
            lives      <= lives_d;
            score      <= score_d;
            hit_pulse  <= hit_d;
            goal_pulse <= goal_d;
            frog_home  <= home_d;
        end
    end

    assign frozen    = (state_q != PLAY);
    assign game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor: table vectors, hand sequences and random traffic
// for collision_monitor, compared against a rule-level model.
module tb_collision_monitor;

    localparam int HOLD   = 8;
    localparam int LIVES0 = 3;
    localparam int MAXS   = 6;
`ifdef COLLISION_GRACE_EN
    localparam int GRACE  = 4;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] lanes = '0;
    logic [3:0]   frog_row = 4'd0;
    logic [3:0]   frog_col = 4'd0;
    logic         start = 1'b0;
    logic [2:0]   speed;
    logic [1:0]   lives;
    logic [7:0]   score;
    logic         hit_pulse, goal_pulse, frog_home, frozen, game_over;
`ifdef COLLISION_GRACE_EN
    logic         grace_active;
`endif

    int total = 0;
    int bad   = 0;

    // Rule-level model of the game
    int m_lives, m_score, m_speed, m_hold_left, m_grace, m_row_q;
    bit m_level, m_over, m_occ_q;
    bit e_hit, e_goal, e_home;

    typedef struct {
        int          row;
        logic [15:0] pat;
        logic [3:0]  fr;
        logic [3:0]  fc;
        logic        st;
        int          n;
        int          lv;
        int          sc;
        int          sp;
        int          go;
    } vec_t;

    vec_t tbl[$];

    collision_monitor #(
        .START_LIVES (LIVES0),
        .HOLD_CYCLES (HOLD),
        .MAX_SPEED   (MAXS)
`ifdef COLLISION_GRACE_EN
        ,
        .GRACE_CYCLES(GRACE)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lanes      (lanes),
        .frog_row   (frog_row),
        .frog_col   (frog_col),
        .start      (start),
        .speed      (speed),
        .lives      (lives),
        .score      (score),
        .hit_pulse  (hit_pulse),
        .goal_pulse (goal_pulse),
        .frog_home  (frog_home),
        .frozen     (frozen),
        .game_over  (game_over)
`ifdef COLLISION_GRACE_EN
        ,
        .grace_active(grace_active)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lives = LIVES0; m_score = 0; m_speed = 0;
        m_hold_left = 0; m_grace = 0; m_row_q = 0;
        m_level = 0; m_over = 0; m_occ_q = 0;
        e_hit = 0; e_goal = 0; e_home = 0;
    endtask

    task automatic model_step();
        bit occ_now;
        bit masked;
        occ_now = lanes[int'(frog_row) * 16 + int'(frog_col)];
        masked  = (m_grace != 0);
        e_hit = 0; e_goal = 0; e_home = 0;
        if (m_over) begin
            if (start) begin
                m_over = 0; m_lives = LIVES0; m_speed = 0; m_score = 0; e_home = 1;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) e_home = 1;
        end else if (m_level) begin
            m_level = 0;
        end else if (m_occ_q && !masked) begin
            e_hit = 1;
            m_lives--;
            if (m_lives == 0) m_over = 1;
            else m_hold_left = HOLD;
        end else if (m_row_q == 15) begin
            e_goal = 1; e_home = 1; m_level = 1;
            m_score = (m_score + 1) % 256;
            m_speed = (m_speed < MAXS) ? m_speed + 1 : MAXS;
        end
`ifdef COLLISION_GRACE_EN
        if (e_home) m_grace = GRACE - 1;
        else if (m_grace > 0) m_grace--;
`endif
        m_occ_q = occ_now;
        m_row_q = int'(frog_row);
    endtask

    task automatic compare_all();
        check("hit_pulse", hit_pulse, e_hit);
        check("goal_pulse", goal_pulse, e_goal);
        check("frog_home", frog_home, e_home);
        check("frozen", frozen, (m_over || m_hold_left > 0 || m_level) ? 1 : 0);
        check("game_over", game_over, m_over);
        check("lives", lives, m_lives);
        check("score", score, m_score);
        check("speed", speed, m_speed);
`ifdef COLLISION_GRACE_EN
        check("grace_active", grace_active, (m_grace != 0) ? 1 : 0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic vec_t mk(int row, logic [15:0] pat, logic [3:0] fr, logic [3:0] fc,
                                logic st, int n, int lv, int sc, int sp, int go);
        vec_t v;
        v.row = row; v.pat = pat; v.fr = fr; v.fc = fc; v.st = st; v.n = n;
        v.lv = lv; v.sc = sc; v.sp = sp; v.go = go;
        return v;
    endfunction

    initial begin
        int fcnt;
        bit found;

        // start in PLAY is ignored
        tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b1, 2, 3, 0, 0, 0));
        // seven goals, frog stepping away after each one
        for (int g = 1; g <= 7; g++) begin
            tbl.push_back(mk(-1, 16'h0000, 4'd15, 4'd5, 1'b0, 2, 3, g, (g < MAXS) ? g : MAXS, 0));
            tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b0, 2, 3, g, (g < MAXS) ? g : MAXS, 0));
        end
        // collision on the goal row: hit wins, score and speed unchanged
        tbl.push_back(mk(15, 16'h0001, 4'd15, 4'd0, 1'b0, 2, 2, 7, 6, 0));
        tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b0, 10, 2, 7, 6, 0));
        tbl.push_back(mk(3, 16'h0008, 4'd3, 4'd3, 1'b0, 2, 1, 7, 6, 0));
        tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b0, 10, 1, 7, 6, 0));
        tbl.push_back(mk(3, 16'h0008, 4'd3, 4'd3, 1'b0, 2, 0, 7, 6, 1));
        tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b0, 3, 0, 7, 6, 1));
        // restart from GAME_OVER
        tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b1, 1, 3, 0, 0, 0));
        tbl.push_back(mk(-1, 16'h0000, 4'd0, 4'd0, 1'b0, 4, 3, 0, 0, 0));

        // reset values
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_lives", lives, LIVES0);
        check("rst_speed", speed, 0);
        check("rst_score", score, 0);
        check("rst_hit", hit_pulse, 0);
        check("rst_goal", goal_pulse, 0);
        check("rst_home", frog_home, 0);
        check("rst_frozen", frozen, 0);
        check("rst_game_over", game_over, 0);
        #2 reset_n = 1'b1;

        // table vectors
        foreach (tbl[i]) begin
            lanes = '0;
            if (tbl[i].row >= 0) lanes[tbl[i].row * 16 +: 16] = tbl[i].pat;
            frog_row = tbl[i].fr;
            frog_col = tbl[i].fc;
            start    = tbl[i].st;
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                start = 1'b0;
            end
            check($sformatf("vec%0d_lives", i), lives, tbl[i].lv);
            check($sformatf("vec%0d_score", i), score, tbl[i].sc);
            check($sformatf("vec%0d_speed", i), speed, tbl[i].sp);
            check($sformatf("vec%0d_game_over", i), game_over, tbl[i].go);
        end

        // single hit: one-cycle pulse, frozen for HOLD cycles, then respawn
        lanes = '0; lanes[3*16 +: 16] = 16'h0008; frog_row = 4'd3; frog_col = 4'd3;
        tick(); tick();
        check("single_hit_pulse", hit_pulse, 1);
        check("single_hit_lives", lives, 2);
        check("single_hit_frozen", frozen, 1);
        lanes = '0; frog_row = 4'd0; frog_col = 4'd0;
        fcnt = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (frog_home) found = 1;
            else if (frozen) fcnt++;
        end
        check("hold_respawn_seen", found, 1);
        check("hold_frozen_cycles", fcnt, HOLD);
        check("hold_released", frozen, 0);

        // asynchronous reset in the middle of HOLD
        lanes[3*16 +: 16] = 16'h0008; frog_row = 4'd3; frog_col = 4'd3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (hit_pulse) found = 1;
        end
        check("second_hit_seen", found, 1);
        lanes = '0; frog_row = 4'd0; frog_col = 4'd0;
        repeat (3) tick();
        check("pre_rst_frozen", frozen, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_lives", lives, LIVES0);
        check("async_rst_frozen", frozen, 0);
        check("async_rst_hit", hit_pulse, 0);
        check("async_rst_home", frog_home, 0);
        check("async_rst_speed", speed, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

`ifdef COLLISION_GRACE_EN
        // grace window after a respawn with the collision held in place
        lanes[3*16 +: 16] = 16'h0008; frog_row = 4'd3; frog_col = 4'd3;
        tick(); tick();
        check("grace_first_hit", hit_pulse, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (frog_home) found = 1;
        end
        check("grace_respawn_seen", found, 1);
        for (int i = 0; i < GRACE - 1; i++) begin
            tick();
            check("grace_masked_hit", hit_pulse, 0);
        end
        tick();
        check("grace_hit_after_window", hit_pulse, 1);
`endif

        // random traffic, frog moves and restarts
        for (int c = 0; c < 800; c++) begin
            lanes = '0;
            for (int r = 1; r < 16; r++) begin
                if (r != 8) lanes[r*16 +: 16] = 16'($urandom & $urandom & $urandom);
            end
            frog_row = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            frog_col = 4'($urandom_range(0, 15));
            start    = ($urandom_range(0, 7) == 0);
            tick();
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
